// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Front-end instruction fetch stage. Owns the PC, issues one
//            outstanding word fetch at a time to the memory controller, and
//            buffers returned words together with their PCs in a circular
//            instruction queue whose head is presented to decode/issue.
//            A clear from commit flushes the queue, abandons any in-flight
//            fetch and redirects the PC.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            rdy                - global enable (0 freezes all state)
//            mem_req/mem_addr   - fetch request, held until mem_done
//            mem_done/mem_data  - one-cycle completion pulse with the word
//            out_valid/out_inst/out_pc/out_ready - queue head handshake
//            clear/clear_pc     - flush and redirect
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int          QUEUE_DEPTH_LOG = 3,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        clear,
    input  logic [31:0] clear_pc
);

    localparam int c_DEPTH = 1 << QUEUE_DEPTH_LOG;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    logic [0:0]                 r_state;
    logic [31:0]                r_pc;
    logic                       r_mem_req;
    logic [31:0]                r_mem_addr;
    logic [QUEUE_DEPTH_LOG-1:0] r_head;
    logic [QUEUE_DEPTH_LOG-1:0] r_tail;
    logic [QUEUE_DEPTH_LOG:0]   r_count;
    logic [31:0]                r_q_inst [c_DEPTH];
    logic [31:0]                r_q_pc   [c_DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Count is one bit wider than the pointers, so its MSB alone marks full.
    assign w_full  = r_count[QUEUE_DEPTH_LOG];
    assign w_empty = (r_count == '0);

    // Clear (and reset) outrank both queue operations; a completion that
    // coincides with a clear belongs to the abandoned path and is dropped.
    assign w_push = !rst && rdy && !clear && (r_state == c_ST_WAIT) && mem_done;
    assign w_pop  = !rst && rdy && !clear && !w_empty && out_ready;

    // Queue storage carries no reset: validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_tail] <= mem_data;
            r_q_pc[r_tail]   <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (rdy) begin
            if (clear) begin
                // Dropping mem_req for at least one cycle tells the memory
                // controller to abort, so no stale completion can follow.
                r_state   <= c_ST_IDLE;
                r_pc      <= clear_pc;
                r_mem_req <= 1'b0;
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
            end else begin
                if (w_pop) begin
                    r_head <= r_head + QUEUE_DEPTH_LOG'(1);
                end
                if (w_push) begin
                    r_tail <= r_tail + QUEUE_DEPTH_LOG'(1);
                    r_pc   <= r_pc + 32'd4;
                end

                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (QUEUE_DEPTH_LOG+1)'(1);
                    2'b01:   r_count <= r_count - (QUEUE_DEPTH_LOG+1)'(1);
                    default: r_count <= r_count;
                endcase

                case (r_state)
                    c_ST_IDLE: begin
                        // A slot is reserved at issue time, so the eventual
                        // push can never overflow the queue.
                        if (!w_full) begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_pc;
                            r_state    <= c_ST_WAIT;
                        end
                    end
                    c_ST_WAIT: begin
                        if (mem_done) begin
                            r_mem_req <= 1'b0;
                            r_state   <= c_ST_IDLE;
                        end
                    end
                    default: begin
                        r_mem_req <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign out_valid = !w_empty;
    assign out_inst  = w_empty ? 32'h0 : r_q_inst[r_head];
    assign out_pc    = w_empty ? 32'h0 : r_q_pc[r_head];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Testbench for inst_fetch. Acts as the memory controller and the
//            consumer, and tracks the expected fetch stream with a queue-based
//            reference model of the fetch rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam int c_DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        clear;
    logic [31:0] clear_pc;

    inst_fetch #(
        .QUEUE_DEPTH_LOG (3),
        .RESET_PC        (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_done  (mem_done),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .clear     (clear),
        .clear_pc  (clear_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: fetched words in program order plus request state.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_req;
    logic [31:0] m_addr;

    // Memory responder settings.
    int          n_tests;
    int          n_fail;
    bit          auto_mem;
    bit          use_fixed;
    logic [31:0] fixed_data;
    int          lat;
    int          wait_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit pop;
        if (rst) begin
            m_q.delete();
            m_pc   = 32'h0;
            m_req  = 1'b0;
            m_addr = 32'h0;
        end else if (rdy) begin
            if (clear) begin
                m_q.delete();
                m_pc  = clear_pc;
                m_req = 1'b0;
            end else begin
                pop = (m_q.size() != 0) && out_ready;
                if (m_req) begin
                    if (mem_done) begin
                        m_q.push_back('{pc: m_addr, inst: mem_data});
                        m_pc  = m_pc + 32'd4;
                        m_req = 1'b0;
                    end
                end else if (m_q.size() < c_DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_pc;
                end
                if (pop) void'(m_q.pop_front());
            end
        end
    endtask

    task automatic check_outputs();
        chk("mem_req", {31'h0, mem_req}, {31'h0, m_req});
        chk("mem_addr", mem_addr, m_addr);
        chk("out_valid", {31'h0, out_valid}, {31'h0, (m_q.size() != 0)});
        chk("out_pc", out_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
        chk("out_inst", out_inst, (m_q.size() != 0) ? m_q[0].inst : 32'h0);
    endtask

    // Inputs are driven around the negedge; the model advances with the DUT
    // at the posedge and outputs are compared at the following negedge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_mem();
        if (!auto_mem) return;
        mem_done = 1'b0;
        if (m_req && rdy && !rst) begin
            if (wait_cnt + 1 >= lat) begin
                mem_done = 1'b1;
                mem_data = use_fixed ? fixed_data : $urandom;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else if (!m_req) begin
            wait_cnt = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_mem();
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_done = 1'b0;
        run(2);
        rst = 1'b0;
    endtask

    // Runs until a request is outstanding, bounded by a cycle budget.
    task automatic wait_req(input string tag);
        for (int i = 0; i < 30 && !m_req; i++) run(1);
        chk(tag, {31'h0, mem_req}, 32'h1);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        rdy        = 1'b1;
        mem_done   = 1'b0;
        mem_data   = 32'h0;
        out_ready  = 1'b0;
        clear      = 1'b0;
        clear_pc   = 32'h0;
        auto_mem   = 1'b1;
        use_fixed  = 1'b0;
        fixed_data = 32'h0;
        lat        = 1;
        wait_cnt   = 0;
        m_q.delete();
        m_pc   = 32'h0;
        m_req  = 1'b0;
        m_addr = 32'h0;

        // Reset state.
        @(negedge clk);
        do_reset();
        chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);

        // First fetch: 3-cycle memory returning a NOP-like word.
        use_fixed  = 1'b1;
        fixed_data = 32'h0000_0013;
        lat        = 3;
        out_ready  = 1'b1;
        run(1);
        chk("first_req_addr", mem_addr, 32'h0);
        for (int i = 0; i < 10 && !out_valid; i++) run(1);
        chk("first_out_pc", out_pc, 32'h0);
        chk("first_out_inst", out_inst, 32'h0000_0013);
        run(20);
        use_fixed = 1'b0;

        // Fill the queue with the consumer stalled, then drain in order.
        do_reset();
        out_ready = 1'b0;
        lat       = 1;
        run(40);
        chk("full_no_req", {31'h0, mem_req}, 32'h0);
        chk("full_head_pc", out_pc, 32'h0);
        chk("full_count", m_q.size(), c_DEPTH);
        chk("full_last_pc", m_q[c_DEPTH-1].pc, 32'h1C);
        out_ready = 1'b1;
        run(40);

        // Clear in WAIT with a coincident mem_done: the word is dropped.
        lat = 50;
        wait_req("clr_wait_req");
        auto_mem = 1'b0;
        clear    = 1'b1;
        clear_pc = 32'h0000_1000;
        mem_done = 1'b1;
        mem_data = 32'hDEAD_BEEF;
        step();
        clear    = 1'b0;
        mem_done = 1'b0;
        chk("clr_out_valid", {31'h0, out_valid}, 32'h0);
        auto_mem = 1'b1;
        wait_cnt = 0;
        lat      = 2;
        run(1);
        chk("clr_new_req", {31'h0, mem_req}, 32'h1);
        chk("clr_new_addr", mem_addr, 32'h0000_1000);
        run(20);

        // Freeze mid-WAIT: rdy low, noisy mem_done/clear/out_ready ignored.
        out_ready = 1'b0;
        run(6);
        lat = 50;
        wait_req("frz_wait_req");
        auto_mem = 1'b0;
        rdy      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_done  = 1'($urandom);
            mem_data  = $urandom;
            out_ready = 1'b1;
            clear     = (i == 2);
            clear_pc  = 32'h0000_2000;
            step();
            chk("frz_mem_req", {31'h0, mem_req}, 32'h1);
        end
        rdy      = 1'b1;
        clear    = 1'b0;
        mem_done = 1'b0;
        auto_mem = 1'b1;
        wait_cnt = 0;
        lat      = 1;
        run(30);

        // PC wrap at the top of the address space.
        auto_mem = 1'b0;
        clear    = 1'b1;
        clear_pc = 32'hFFFF_FFFC;
        step();
        clear    = 1'b0;
        auto_mem = 1'b1;
        wait_cnt = 0;
        lat      = 2;
        out_ready = 1'b0;
        run(12);
        chk("wrap_pc0", m_q.size() >= 2 ? out_pc : 32'hX, 32'hFFFF_FFFC);
        out_ready = 1'b1;
        run(1);
        chk("wrap_pc1", out_pc, 32'h0000_0000);
        run(10);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            rdy       = ($urandom_range(0, 9) != 0);
            out_ready = 1'($urandom);
            clear     = ($urandom_range(0, 39) == 0);
            clear_pc  = $urandom;
            rst       = ($urandom_range(0, 149) == 0);
            drive_mem();
            step();
        end
        rst   = 1'b0;
        clear = 1'b0;
        rdy   = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
